// File: rtl/serial_divider_pkg.sv
// Shared definitions for the serial restoring divider: FSM encoding and counter sizing.
package serial_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_divider_if.sv
// Operand/result valid-ready bundle for serial_divider.
// div_by_zero exists only when SERIAL_DIV_ZERO_CHECK_EN is defined.
interface serial_divider_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
`ifdef SERIAL_DIV_ZERO_CHECK_EN
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
`else
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder
    );
`endif
endinterface

// File: rtl/serial_divider_step.sv
// One restoring-division iteration: shift in a dividend bit, ripple-subtract the divisor,
// keep the difference if it did not go negative.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);
    logic [WIDTH:0] a;
    logic [WIDTH:0] b;
    logic [WIDTH:0] diff;
    logic           borrow;

    always_comb begin
        a      = {rem_in, bit_in};
        b      = {1'b0, divisor};
        diff   = '0;
        borrow = 1'b0;
        for (int i = 0; i <= WIDTH; i++) begin
            diff[i] = a[i] ^ b[i] ^ borrow;
            borrow  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow);
        end
        q_bit = ~diff[WIDTH];
        // the kept remainder is always below the divisor, so its top bit is zero
        rem_out = q_bit ? diff[WIDTH-1:0] : a[WIDTH-1:0];
    end
endmodule

// File: rtl/serial_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional SERIAL_DIV_ZERO_CHECK_EN: divisor-0 short-cut straight to DONE with div_by_zero flag.
module serial_divider
    import serial_div_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic            clock,
    input  logic            reset,
    serial_divider_if.slave bus
);
    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_shift, q_nxt, dvs, rem, rem_nxt, quo_r, rem_r;
    logic [CNT_W-1:0] cnt;
    logic             q_bit, accept, last_step, zero_skip;
    logic             in_ready_c, out_valid_c;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .bit_in  (q_shift[WIDTH-1]),
        .divisor (dvs),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    assign q_nxt     = {q_shift[WIDTH-2:0], q_bit};
    assign accept    = bus.in_valid && (state == IDLE);
    assign last_step = (cnt == CNT_W'(1));
`ifdef SERIAL_DIV_ZERO_CHECK_EN
    assign zero_skip = (bus.divisor == '0);
`else
    assign zero_skip = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_nxt = zero_skip ? DONE : BUSY;
            end
            BUSY: begin
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SERIAL_DIV_ZERO_CHECK_EN
    logic dbz_r;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)       dbz_r <= 1'b0;
        else if (accept) dbz_r <= zero_skip;
    end

    assign bus.div_by_zero = dbz_r;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_shift <= '0;
            dvs     <= '0;
            rem     <= '0;
            cnt     <= '0;
            quo_r   <= '0;
            rem_r   <= '0;
        end else if (accept) begin
            q_shift <= bus.dividend;
            dvs     <= bus.divisor;
            rem     <= '0;
            cnt     <= CNT_W'(WIDTH);
            if (zero_skip) begin
                quo_r <= '1;
                rem_r <= bus.dividend;
            end
        end else if (state == BUSY) begin
            q_shift <= q_nxt;
            rem     <= rem_nxt;
            cnt     <= cnt - CNT_W'(1);
            if (last_step) begin
                quo_r <= q_nxt;
                rem_r <= rem_nxt;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.quotient  = quo_r;
    assign bus.remainder = rem_r;
endmodule

// File: tb/tb_serial_divider.sv
// Directed scoreboard bench for serial_divider (WIDTH=8); builds with or without
// SERIAL_DIV_ZERO_CHECK_EN.
module tb_serial_divider;
    localparam int WIDTH = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    serial_divider_if #(.WIDTH(WIDTH)) bif ();

    serial_divider #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif)
    );

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
        int               edges;
    } exp_t;

    exp_t             sb[$];
    int               checks   = 0;
    int               failures = 0;
    logic [WIDTH-1:0] last_q   = '0;
    logic [WIDTH-1:0] last_r   = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  32'(bif.in_ready),  1);
        chk({tag, "_out_valid"}, 32'(bif.out_valid), 0);
        chk({tag, "_quotient"},  32'(bif.quotient),  0);
        chk({tag, "_remainder"}, 32'(bif.remainder), 0);
`ifdef SERIAL_DIV_ZERO_CHECK_EN
        chk({tag, "_dbz"},       32'(bif.div_by_zero), 0);
`endif
    endtask

    // Called at a negedge; returns at a negedge one cycle after the result handshake.
    task automatic do_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int hold, input bit keep_valid);
        exp_t e, got;
        int   k;
        bit   busy_ok, stable_ok;
        e.q = (b == 0) ? {WIDTH{1'b1}} : a / b;
        e.r = (b == 0) ? a : a % b;
`ifdef SERIAL_DIV_ZERO_CHECK_EN
        e.dbz   = (b == 0);
        e.edges = (b == 0) ? 1 : WIDTH + 1;
`else
        e.dbz   = 1'b0;
        e.edges = WIDTH + 1;
`endif
        chk({tag, "_idle_ready"}, 32'(bif.in_ready), 1);
        bif.in_valid  = 1'b1;
        bif.dividend  = a;
        bif.divisor   = b;
        bif.out_ready = (hold == 0);
        sb.push_back(e);

        k       = 0;
        busy_ok = 1'b1;
        do begin
            @(posedge clock);
            k++;
            @(negedge clock);
            if (!keep_valid) bif.in_valid = 1'b0;
            if (!bif.out_valid && (bif.in_ready !== 1'b0 || bif.quotient !== last_q ||
                                   bif.remainder !== last_r))
                busy_ok = 1'b0;
        end while (!bif.out_valid && k < 40);

        chk({tag, "_edges_to_valid"}, 32'(k), 32'(e.edges));
        chk({tag, "_busy_hold"}, 32'(busy_ok), 1);
        got = sb.pop_front();
        chk({tag, "_quotient"},  32'(bif.quotient),  32'(got.q));
        chk({tag, "_remainder"}, 32'(bif.remainder), 32'(got.r));
`ifdef SERIAL_DIV_ZERO_CHECK_EN
        chk({tag, "_dbz"}, 32'(bif.div_by_zero), 32'(got.dbz));
`endif

        stable_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (bif.quotient !== got.q || bif.remainder !== got.r ||
                bif.out_valid !== 1'b1 || bif.in_ready !== 1'b0)
                stable_ok = 1'b0;
            @(posedge clock);
            @(negedge clock);
        end
        chk({tag, "_stall_stable"}, 32'(stable_ok), 1);
        chk({tag, "_done_valid"}, 32'(bif.out_valid), 1);
        chk({tag, "_done_ready"}, 32'(bif.in_ready), 0);

        bif.out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk({tag, "_post_valid"}, 32'(bif.out_valid), 0);
        chk({tag, "_post_ready"}, 32'(bif.in_ready), 1);
        chk({tag, "_post_quotient"}, 32'(bif.quotient), 32'(got.q));
        bif.in_valid = 1'b0;
        last_q = got.q;
        last_r = got.r;
    endtask

    initial begin
        reset         = 1'b1;
        bif.in_valid  = 1'b0;
        bif.dividend  = '0;
        bif.divisor   = '0;
        bif.out_ready = 1'b1;
        repeat (2) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clock);

        do_op("d100_7", 8'd100, 8'd7, 0, 1'b0);
        do_op("d255_1", 8'd255, 8'd1, 0, 1'b0);
        do_op("d5_9",   8'd5,   8'd9, 0, 1'b0);
        do_op("d37_0",  8'd37,  8'd0, 0, 1'b0);
        do_op("d10_3",  8'd10,  8'd3, 0, 1'b0);
        do_op("d200_13", 8'd200, 8'd13, 5, 1'b1);

        // reset asserted mid-cycle three edges into a 123/4 operation
        bif.in_valid = 1'b1;
        bif.dividend = 8'd123;
        bif.divisor  = 8'd4;
        @(posedge clock);
        @(negedge clock);
        bif.in_valid = 1'b0;
        chk("abort_busy_ready", 32'(bif.in_ready), 0);
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        #1 check_reset_outputs("abort_async");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_reset_outputs("abort_release");
        last_q = '0;
        last_r = '0;

        do_op("d9_2", 8'd9, 8'd2, 0, 1'b0);
        chk("scoreboard_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_divider.md
Name: serial_divider

Overview:
Multi-cycle unsigned restoring divider. It is the inverse arithmetic counterpart of the combinational adder: each cycle it does one shift and one trial subtraction instead of one ripple add. Sits behind generated datapath logic wherever a quotient and remainder are needed and a single-cycle array is too large. Valid/ready handshake on both the operand side and the result side.

Parameters:
WIDTH, 8, operand, quotient and remainder width in bits (must be >= 2).
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high; clears all state.
in_valid  input  1  operands present.
in_ready  output  1  divider can accept operands.
dividend  input  WIDTH  unsigned numerator.
divisor  input  WIDTH  unsigned denominator.
out_valid  output  1  result present.
out_ready  input  1  consumer takes result.
quotient  output  WIDTH  floor(dividend/divisor).
remainder  output  WIDTH  dividend mod divisor.
div_by_zero  output  1  present only with SERIAL_DIV_ZERO_CHECK_EN; set with a divisor-0 result.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch dividend and divisor, clear the partial remainder (WIDTH+1 bits), set counter=WIDTH, then go to BUSY. Operands are sampled only on that edge.
- BUSY: in_ready=0. Each cycle:
  - trial = {rem[WIDTH-1:0], q_shift MSB} - {1'b0, divisor}, computed at WIDTH+1 bits.
  - If the trial MSB is 0: rem=trial, shift 1 into the quotient.
  - Otherwise: rem=shifted value, shift 0 into the quotient.
  - Decrement the counter. The step that brings the counter to 0 moves the FSM to DONE.
- Latency: acceptance at edge T gives out_valid=1 after edge T+WIDTH. A new operand can be accepted at the earliest one edge after the result handshake.
- DONE: out_valid=1. quotient and remainder hold the final values and stay stable while out_ready=0, for any duration. On out_valid&out_ready, go to IDLE. in_ready is not asserted in the same cycle; there is no pass-through.
- quotient and remainder are registered and change only on the DONE entry edge. They keep their last value in IDLE.
- Divisor 0 without the macro: normal iteration yields quotient={WIDTH{1}} and remainder=dividend. This is required, not incidental.
- Divisor > dividend: quotient=0, remainder=dividend.
- Asynchronous reset mid-BUSY or in DONE aborts the operation immediately. The pending result is discarded and all outputs return to their reset values.
- in_valid while BUSY or DONE is ignored; no buffering.

Optional Feature:
SERIAL_DIV_ZERO_CHECK_EN:
- Defined:
  - The div_by_zero port exists.
  - An accepted divisor of 0 skips BUSY and goes IDLE->DONE in one edge, with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
  - div_by_zero is cleared on the next acceptance and on reset.
- Undefined: no port; divisor 0 takes the full WIDTH-cycle path with the same quotient and remainder values.

Decomposition:
- Shared package serial_div_pkg:
  - state encoding constants IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - a localparam function for CNT_W.
- One natural combinational sub-module: div_step (WIDTH parameter).
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
  - Structurally it is a ripple subtractor in the same style as the generated adder logic.

Test Plan:
- WIDTH=8, 100/7, out_ready=1 -> out_valid exactly 8 edges after acceptance, quotient=14, remainder=2; in_ready=0 throughout BUSY/DONE.
- 255/1, then 5/9 back-to-back -> 255 r0, then 0 r5; second acceptance no earlier than one edge after the first result handshake.
- 37/0, both builds -> quotient=255, remainder=37. Without the macro: latency 8. With the macro: latency 1 and div_by_zero=1, cleared on the next accept of 10/3 (-> 3 r1).
- 200/13 with out_ready held low 5 cycles after out_valid -> quotient=15, remainder=5 held stable; no new accept while in_valid=1; handshake on the 6th cycle.
- 123/4, reset pulsed 3 cycles after acceptance (asynchronous, mid-cycle) -> outputs drop to reset values immediately, in_ready=1 after release. A subsequent 9/2 gives 4 r1.
